line_mem_responder: RTL and testbench

- Responder end of the 256-bit cache-line memory interface driven by the data cache: accepts line-sized read/write requests, models a fixed access latency, and completes each request with a one-cycle ack.
- Sits below the dcache, replacing the simple behavioural data memory with a cycle-accurate FSM, abort handling and busy/status visibility for pipeline-stall testing.
- Backing store is a line-addressed array of 256-bit entries, preloadable hierarchically by the bench (storage name memory).

---
 rtl/line_mem_responder.sv | 93 +++++++++
 tb/tb_line_mem_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
// line_mem_responder: 256-bit cache-line memory responder with fixed access latency, abort and busy status.
// Optional LINE_MEM_RANGE_CHECK_EN adds err_o and suppresses accesses whose address exceeds the array.
module line_mem_responder #(
    parameter int LINE_W  = 256,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o
`ifdef LINE_MEM_RANGE_CHECK_EN
    ,output logic             err_o
`endif
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [7:0] LAST_WAIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t            r_state, w_next;
    logic [7:0]        r_cnt;
    logic [IW-1:0]     r_idx;
    logic              r_write;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_data;
    logic [LINE_W-1:0] memory [DEPTH];
    logic              w_accept, w_fire, w_err;
    logic              w_unused;

`ifdef LINE_MEM_RANGE_CHECK_EN
    logic r_oor;
    assign w_err    = r_oor;
    assign w_unused = ^addr_i[4:0];
`else
    assign w_err    = 1'b0;
    assign w_unused = ^{addr_i[4:0], addr_i[31:5+IW]};
`endif

    assign w_accept = r_state == S_IDLE && enable_i;
    // The access happens on the edge that enters ACK, never under reset.
    assign w_fire   = !rst_i && r_state == S_WAIT && w_next == S_ACK;
    assign data_o   = r_data;

    always_ff @(posedge clk_i) begin
        r_state <= rst_i ? S_IDLE : w_next;
    end

    always_comb begin
        w_next = (r_state == S_IDLE) ? (enable_i ? S_WAIT : S_IDLE) :
                 (r_state == S_WAIT) ? (!enable_i ? S_IDLE : (r_cnt == LAST_WAIT ? S_ACK : S_WAIT)) :
                 S_IDLE;
    end

    always_comb begin
        ack_o  = r_state == S_ACK;
        busy_o = r_state == S_WAIT;
`ifdef LINE_MEM_RANGE_CHECK_EN
        err_o  = r_state == S_ACK && r_oor;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_data <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= 8'd1;
                r_idx   <= addr_i[5+IW-1:5];
                r_write <= write_i;
                r_wdata <= data_i;
`ifdef LINE_MEM_RANGE_CHECK_EN
                r_oor   <= |addr_i[31:5+IW];
`endif
            end else begin
                r_cnt <= (r_state == S_WAIT) ? r_cnt + 8'd1 : '0;
            end
            if (w_fire)
                r_data <= w_err ? '0 : (r_write ? r_data : memory[r_idx]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_fire && r_write && !w_err)
            memory[r_idx] <= r_wdata;
    end
endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: directed vector table plus hand sequences for abort, reset, back-to-back and range cases.
module tb_line_mem_responder;
    localparam logic [255:0] P0   = {8{32'h1234_5678}};
    localparam logic [255:0] P1   = 256'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_7777_6666_5555_4444_3333_2222_1111_0000;
    localparam logic [255:0] P5   = {8{32'h5555_0005}};
    localparam logic [255:0] P18  = {8{32'h0BAD_F00D}};
    localparam logic [255:0] P32  = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] P511 = {8{32'h0511_0511}};
    localparam logic [255:0] ECFA = {16{16'hECFA}};
    localparam logic [255:0] W511 = {8{32'hA5A5_5A5A}};
    localparam logic [255:0] GARB = {8{32'h0BAD_0BAD}};
    localparam logic [255:0] RNG  = {8{32'hFACE_0001}};

    logic         clk = 1'b0, rst = 1'b1, en = 1'b0, wr = 1'b0;
    logic [31:0]  addr = '0;
    logic [255:0] din = '0, dout;
    logic         ack, busy, err;
    int           total = 0, bad = 0;

    line_mem_responder dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(din), .enable_i(en),
        .write_i(wr), .ack_o(ack), .data_o(dout), .busy_o(busy)
`ifdef LINE_MEM_RANGE_CHECK_EN
        , .err_o(err)
`endif
    );
`ifndef LINE_MEM_RANGE_CHECK_EN
    assign err = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Issue one request, scramble the inputs mid-flight, and report what came back at ack.
    task automatic run_req(input logic [31:0] a, input logic [255:0] d, input logic w, input logic [255:0] old,
                           output logic [255:0] got, output logic got_err, output int lat, output int bz);
        int n = 0;
        bit done = 0;
        lat = -1; bz = 0; got = '0; got_err = 1'b0;
        @(negedge clk);
        addr = a; din = d; wr = w; en = 1'b1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) bz++;
            if (n == 3) begin addr = ~a; din = ~d; wr = ~w; end
            if (w && n == 5) chk("mem_before_ack", dut.memory[a[13:5]], old);
            if (ack) begin lat = n; got = dout; got_err = err; done = 1; en = 1'b0; end
        end
        en = 1'b0;
        chk("ack_seen", 256'(done), 256'd1);
        @(negedge clk);
        chk("ack_single", 256'(ack), 256'd0);
    endtask

    typedef struct {
        logic [31:0]  a;
        logic [255:0] d;
        logic         w;
        logic [255:0] old;
        logic [255:0] exp;
    } vec_t;

    vec_t v[7];

    initial begin
        logic [255:0] got;
        logic         gerr;
        int           lat, bz, acks, c, k;
        int           ack_c[2];
        logic [255:0] ack_d[2];

        dut.memory[0]   = P0;
        dut.memory[1]   = P1;
        dut.memory[5]   = P5;
        dut.memory[18]  = P18;
        dut.memory[32]  = P32;
        dut.memory[511] = P511;

        v[0] = '{32'h0000_0020, 256'd0, 1'b0, 256'd0, P1};
        v[1] = '{32'h0000_0240, ECFA,   1'b1, P18,    P1};
        v[2] = '{32'h0000_0240, 256'd0, 1'b0, 256'd0, ECFA};
        v[3] = '{32'h0000_025F, 256'd0, 1'b0, 256'd0, ECFA};
        v[4] = '{32'h0000_3FE0, W511,   1'b1, P511,   ECFA};
        v[5] = '{32'h0000_3FE0, 256'd0, 1'b0, 256'd0, W511};
        v[6] = '{32'h0000_0000, 256'd0, 1'b0, 256'd0, P0};

        repeat (3) @(negedge clk);
        chk("reset_ack", 256'(ack), 256'd0);
        chk("reset_busy", 256'(busy), 256'd0);
        chk("reset_data", dout, 256'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_req(v[i].a, v[i].d, v[i].w, v[i].old, got, gerr, lat, bz);
            chk($sformatf("vec%0d_latency", i), 256'(lat), 256'd10);
            chk($sformatf("vec%0d_busy_cycles", i), 256'(bz), 256'd9);
            chk($sformatf("vec%0d_data", i), got, v[i].exp);
            if (v[i].w) chk($sformatf("vec%0d_mem_after", i), dut.memory[v[i].a[13:5]], v[i].d);
        end

        // Abort a write to line 32 while the counter is at 4.
        @(negedge clk);
        addr = 32'h0000_0400; din = GARB; wr = 1'b1; en = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", 256'(busy), 256'd1);
        en = 1'b0;
        @(negedge clk);
        chk("abort_busy_after", 256'(busy), 256'd0);
        acks = 0;
        repeat (15) begin @(negedge clk); if (ack) acks++; end
        chk("abort_no_ack", 256'(acks), 256'd0);
        chk("abort_mem_intact", dut.memory[32], P32);
        run_req(32'h0000_0400, 256'd0, 1'b0, 256'd0, got, gerr, lat, bz);
        chk("after_abort_latency", 256'(lat), 256'd10);
        chk("after_abort_data", got, P32);

        // Reset a write to line 5 while the counter is at 5.
        @(negedge clk);
        addr = 32'h0000_00A0; din = GARB; wr = 1'b1; en = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        chk("midrst_ack", 256'(ack), 256'd0);
        chk("midrst_busy", 256'(busy), 256'd0);
        chk("midrst_data", dout, 256'd0);
        acks = 0;
        repeat (15) begin @(negedge clk); if (ack) acks++; end
        chk("midrst_no_ack", 256'(acks), 256'd0);
        chk("midrst_mem_intact", dut.memory[5], P5);
        run_req(32'h0000_00A0, 256'd0, 1'b0, 256'd0, got, gerr, lat, bz);
        chk("midrst_read_back", got, P5);

        // Back-to-back reads with enable held across the first ack.
        @(negedge clk);
        addr = 32'h0; wr = 1'b0; en = 1'b1;
        c = 0; k = 0;
        ack_c[0] = -100; ack_c[1] = 0;
        ack_d[0] = '0; ack_d[1] = '0;
        while (k < 2 && c < 60) begin
            @(negedge clk);
            c++;
            if (ack) begin
                ack_c[k] = c; ack_d[k] = dout; k++;
                if (k == 1) addr = 32'h0000_0020; else en = 1'b0;
            end
        end
        en = 1'b0;
        chk("b2b_ack_count", 256'(k), 256'd2);
        chk("b2b_first_latency", 256'(ack_c[0]), 256'd10);
        chk("b2b_spacing", 256'(ack_c[1] - ack_c[0]), 256'd11);
        chk("b2b_data0", ack_d[0], P0);
        chk("b2b_data1", ack_d[1], P1);

        // Address above the index field.
        run_req(32'h0010_0000, RNG, 1'b1, P0, got, gerr, lat, bz);
        chk("range_latency", 256'(lat), 256'd10);
`ifdef LINE_MEM_RANGE_CHECK_EN
        chk("range_err", 256'(gerr), 256'd1);
        chk("range_data", got, 256'd0);
        chk("range_mem0", dut.memory[0], P0);
`else
        chk("range_err", 256'(gerr), 256'd0);
        chk("range_data", got, P1);
        chk("range_alias_mem0", dut.memory[0], RNG);
`endif
        run_req(32'h0, 256'd0, 1'b0, 256'd0, got, gerr, lat, bz);
`ifdef LINE_MEM_RANGE_CHECK_EN
        chk("range_read0", got, P0);
`else
        chk("range_read0", got, RNG);
`endif
        chk("range_read0_err", 256'(gerr), 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
